// File: rtl/axis_snoop_pkg.sv
// -----------------------------------------------------------------------------
// axis_snoop_pkg
// Purpose : Shared types and constants for the AXI-Stream snooper.
//   snoop_state_t  - capture FSM states
//   MODE_CONT      - continuous capture mode
//   MODE_PKT       - single-packet capture mode
//   level_width()  - bit width of a FIFO occupancy count for a given depth
// -----------------------------------------------------------------------------
package axis_snoop_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOP = 2'd1,
    CAPTURE  = 2'd2,
    DONE     = 2'd3
  } snoop_state_t;

  localparam logic MODE_CONT = 1'b0;
  localparam logic MODE_PKT  = 1'b1;

  // Occupancy must represent 0..depth inclusive, hence the extra bit.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/snoop_fifo.sv
// -----------------------------------------------------------------------------
// snoop_fifo
// Purpose : Synchronous first-word-fall-through FIFO used as the capture store.
// Ports   :
//   clk, rst_n   - clock and asynchronous active-low reset
//   flush        - synchronous empty (contents discarded)
//   wr_en, din   - write request and data; accepted when not full, or when a
//                  pop happens in the same cycle
//   rd_en        - pop request; ignored while empty
//   dout         - head entry (zero while empty)
//   empty, full  - status flags
//   level        - current occupancy
// -----------------------------------------------------------------------------
module snoop_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_do_rd;
  logic             w_do_wr;

  assign empty   = (r_count == '0);
  assign full    = (r_count == (AW+1)'(DEPTH));
  assign level   = r_count;
  assign w_do_rd = rd_en & ~empty;
  // A full FIFO can still take a write when the head leaves in the same cycle.
  assign w_do_wr = wr_en & (~full | w_do_rd);
  assign dout    = empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_do_wr && !flush) begin
      r_mem[r_wptr] <= din;
    end
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_wr) r_wptr <= r_wptr + 1'b1;
      if (w_do_rd) r_rptr <= r_rptr + 1'b1;
      if (w_do_wr && !w_do_rd)      r_count <= r_count + 1'b1;
      else if (!w_do_wr && w_do_rd) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/axis_stream_snooper.sv
// -----------------------------------------------------------------------------
// axis_stream_snooper
// Purpose : Passive AXI-Stream tap. Never drives tready. Tracks the latest
//           extracted field plus beat/packet counters, and captures decimated
//           samples (continuously or one aligned packet) into a FWFT FIFO.
// Ports   :
//   s00_axis_aclk, s00_axis_aresetn  - clock, async active-low reset
//   mon_tvalid/tready/tlast/tdata     - monitored stream
//   arm, stop, clear                  - control pulses (clear > stop > arm)
//   mode, decim                       - capture mode (sampled on arm), decimation
//   snooped_tdata, snooped_valid      - last handshake field and update pulse
//   beat_count, pkt_count             - saturating handshake / tlast counters
//   rd_tdata, rd_tlast, rd_tvalid,
//   rd_tready, fill_level             - capture FIFO read side
//   overflow                          - sticky dropped-beat flag
//   busy, done                        - capture FSM status
// -----------------------------------------------------------------------------
module axis_stream_snooper
  import axis_snoop_pkg::*;
#(
  parameter int C_AXIS_TDATA_WIDTH = 64,
  parameter int C_SNOOP_LSB        = 32,
  parameter int C_SNOOP_WIDTH      = 32,
  parameter int C_DEPTH            = 16,
  parameter int C_CNT_WIDTH        = 32
) (
  input  logic                              s00_axis_aclk,
  input  logic                              s00_axis_aresetn,
  input  logic                              mon_tvalid,
  input  logic                              mon_tready,
  input  logic                              mon_tlast,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]     mon_tdata,
  input  logic                              arm,
  input  logic                              stop,
  input  logic                              clear,
  input  logic                              mode,
  input  logic [7:0]                        decim,
  output logic [C_SNOOP_WIDTH-1:0]          snooped_tdata,
  output logic                              snooped_valid,
  output logic [C_CNT_WIDTH-1:0]            beat_count,
  output logic [C_CNT_WIDTH-1:0]            pkt_count,
  output logic [C_SNOOP_WIDTH-1:0]          rd_tdata,
  output logic                              rd_tlast,
  output logic                              rd_tvalid,
  input  logic                              rd_tready,
  output logic [level_width(C_DEPTH)-1:0]   fill_level,
  output logic                              overflow,
  output logic                              busy,
  output logic                              done
);

  if (C_SNOOP_LSB + C_SNOOP_WIDTH > C_AXIS_TDATA_WIDTH) begin : g_bad_field
    $error("snoop field exceeds tdata width");
  end
  if (C_DEPTH < 2 || (C_DEPTH & (C_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("C_DEPTH must be a power of two >= 2");
  end

  snoop_state_t             r_state;
  logic                     r_mode;
  logic [7:0]               r_decim_cnt;
  logic                     r_sop;
  logic                     r_overflow;
  logic [C_SNOOP_WIDTH-1:0] r_snoop;
  logic                     r_snoop_valid;
  logic [C_CNT_WIDTH-1:0]   r_beat;
  logic [C_CNT_WIDTH-1:0]   r_pkt;

  logic                     w_hs;
  logic [C_SNOOP_WIDTH-1:0] w_field;
  logic                     w_eligible;
  logic                     w_keep;
  logic                     w_pop;
  logic                     w_empty;
  logic                     w_full;
  logic                     w_write;
  logic                     w_drop;
  logic [C_SNOOP_WIDTH:0]   w_dout;
  logic                     w_unused_bits;

  assign w_hs          = mon_tvalid & mon_tready;
  assign w_field       = mon_tdata[C_SNOOP_LSB +: C_SNOOP_WIDTH];
  assign w_unused_bits = ^mon_tdata;
  assign w_pop         = ~w_empty & rd_tready;

  // Control pulses pre-empt capture: a beat coinciding with clear or stop is
  // never considered for storage.
  assign w_eligible = w_hs & ~clear & ~stop &
                      ((r_state == CAPTURE) | ((r_state == WAIT_SOP) & r_sop));
  // In packet mode the closing beat is always kept so the packet ends cleanly.
  assign w_keep  = w_eligible &
                   ((r_decim_cnt == 8'd0) | ((r_mode == MODE_PKT) & mon_tlast));
  assign w_write = w_keep & (~w_full | w_pop);
  assign w_drop  = w_keep & w_full & ~w_pop;

  snoop_fifo #(
    .WIDTH (C_SNOOP_WIDTH + 1),
    .DEPTH (C_DEPTH)
  ) u_fifo (
    .clk   (s00_axis_aclk),
    .rst_n (s00_axis_aresetn),
    .flush (clear),
    .wr_en (w_keep),
    .din   ({mon_tlast, w_field}),
    .rd_en (rd_tready),
    .dout  (w_dout),
    .empty (w_empty),
    .full  (w_full),
    .level (fill_level)
  );

  // Snoop path and counters run in every FSM state.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      r_snoop       <= '0;
      r_snoop_valid <= 1'b0;
      r_beat        <= '0;
      r_pkt         <= '0;
      r_sop         <= 1'b1;
    end else begin
      r_snoop_valid <= w_hs;
      if (w_hs) begin
        r_snoop <= w_field;
        r_sop   <= mon_tlast;
      end
      if (clear) begin
        r_beat <= '0;
        r_pkt  <= '0;
      end else begin
        if (w_hs && (r_beat != '1))             r_beat <= r_beat + 1'b1;
        if (w_hs && mon_tlast && (r_pkt != '1)) r_pkt  <= r_pkt + 1'b1;
      end
    end
  end

  // Capture FSM, latched mode, decimation counter and sticky overflow.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      r_state     <= IDLE;
      r_mode      <= MODE_CONT;
      r_decim_cnt <= 8'd0;
      r_overflow  <= 1'b0;
    end else if (clear) begin
      r_state     <= IDLE;
      r_decim_cnt <= 8'd0;
      r_overflow  <= 1'b0;
    end else if (stop) begin
      if (r_state == WAIT_SOP || r_state == CAPTURE) r_state <= IDLE;
    end else begin
      if (arm && (r_state == IDLE || r_state == DONE)) begin
        r_state     <= (mode == MODE_PKT) ? WAIT_SOP : CAPTURE;
        r_mode      <= mode;
        r_decim_cnt <= 8'd0;
      end
      if (w_eligible) begin
        if ((r_mode == MODE_PKT) && mon_tlast) r_decim_cnt <= 8'd0;
        else if (r_decim_cnt == decim)         r_decim_cnt <= 8'd0;
        else                                   r_decim_cnt <= r_decim_cnt + 8'd1;

        if (w_drop) r_overflow <= 1'b1;

        if ((r_mode == MODE_PKT) && (w_drop || (w_write && mon_tlast)))
          r_state <= DONE;
        else if (r_state == WAIT_SOP)
          r_state <= CAPTURE;
      end
    end
  end

  assign snooped_tdata = r_snoop;
  assign snooped_valid = r_snoop_valid;
  assign beat_count    = r_beat;
  assign pkt_count     = r_pkt;
  assign rd_tdata      = w_dout[C_SNOOP_WIDTH-1:0];
  assign rd_tlast      = w_dout[C_SNOOP_WIDTH];
  assign rd_tvalid     = ~w_empty;
  assign overflow      = r_overflow;
  assign busy          = (r_state == WAIT_SOP) || (r_state == CAPTURE);
  assign done          = (r_state == DONE);

endmodule

// File: tb/tb_axis_stream_snooper.sv
// -----------------------------------------------------------------------------
// tb_axis_stream_snooper
// Self-checking bench: a table of snoop vectors, hand-written capture
// sequences, and a randomized run compared against a queue-based model.
// -----------------------------------------------------------------------------
module tb_axis_stream_snooper;

  logic        clock = 1'b0;
  logic        resetN;
  logic        monTvalid, monTready, monTlast;
  logic [63:0] monTdata;
  logic        arm, stop, clear, mode;
  logic [7:0]  decim;
  logic [31:0] snoopedTdata;
  logic        snoopedValid;
  logic [31:0] beatCount, pktCount;
  logic [31:0] rdTdata;
  logic        rdTlast, rdTvalid, rdTready;
  logic [4:0]  fillLevel;
  logic        overflow, busy, done;

  always #5 clock = ~clock;

  axis_stream_snooper dut (
    .s00_axis_aclk    (clock),
    .s00_axis_aresetn (resetN),
    .mon_tvalid       (monTvalid),
    .mon_tready       (monTready),
    .mon_tlast        (monTlast),
    .mon_tdata        (monTdata),
    .arm              (arm),
    .stop             (stop),
    .clear            (clear),
    .mode             (mode),
    .decim            (decim),
    .snooped_tdata    (snoopedTdata),
    .snooped_valid    (snoopedValid),
    .beat_count       (beatCount),
    .pkt_count        (pktCount),
    .rd_tdata         (rdTdata),
    .rd_tlast         (rdTlast),
    .rd_tvalid        (rdTvalid),
    .rd_tready        (rdTready),
    .fill_level       (fillLevel),
    .overflow         (overflow),
    .busy             (busy),
    .done             (done)
  );

  int nChecks = 0;
  int nFails  = 0;

  // Reference model: the capture store is a plain queue of {tlast, field}.
  localparam int DEPTH = 16;
  logic [31:0] mSnoop;
  logic        mSnoopValid;
  logic [31:0] mBeat, mPkt;
  logic [32:0] mQ[$];
  logic        mOverflow;
  logic        mRunning;    // capturing (waiting for SOP or storing)
  logic        mWaitSop;    // still looking for the first beat of a packet
  logic        mFinished;   // packet capture completed
  logic        mPktMode;
  int          mSince;      // eligible beats since the last kept one
  logic        mSop;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mSnoop = 0; mSnoopValid = 0; mBeat = 0; mPkt = 0;
    mQ.delete(); mOverflow = 0;
    mRunning = 0; mWaitSop = 0; mFinished = 0; mPktMode = 0;
    mSince = 0; mSop = 1;
  endtask

  task automatic modelStep();
    logic        hs;
    logic [31:0] field;
    logic        wasFull, pop, eligible, keep;
    hs       = monTvalid & monTready;
    field    = monTdata[63:32];
    wasFull  = (mQ.size() == DEPTH);
    pop      = (mQ.size() > 0) && rdTready;
    eligible = hs && mRunning && (!mWaitSop || mSop);
    mSnoopValid = hs;
    if (hs) mSnoop = field;
    if (clear) begin
      mQ.delete(); mBeat = 0; mPkt = 0; mOverflow = 0;
      mRunning = 0; mWaitSop = 0; mFinished = 0; mSince = 0;
    end else begin
      if (hs && mBeat != 32'hFFFF_FFFF) mBeat++;
      if (hs && monTlast && mPkt != 32'hFFFF_FFFF) mPkt++;
      if (pop) void'(mQ.pop_front());
      if (stop) begin
        mRunning = 0; mWaitSop = 0;
      end else if (arm && !mRunning) begin
        mRunning = 1; mFinished = 0; mWaitSop = mode;
        mPktMode = mode; mSince = 0;
      end else if (eligible) begin
        keep = (mSince == 0) || (mPktMode && monTlast);
        if (mPktMode && monTlast) mSince = 0;
        else mSince = (mSince == int'(decim)) ? 0 : mSince + 1;
        mWaitSop = 0;
        if (keep) begin
          if (!wasFull || pop) begin
            mQ.push_back({monTlast, field});
            if (mPktMode && monTlast) begin mRunning = 0; mFinished = 1; end
          end else begin
            mOverflow = 1;
            if (mPktMode) begin mRunning = 0; mFinished = 1; end
          end
        end
      end
    end
    if (hs) mSop = monTlast;
  endtask

  task automatic compareModel();
    checkOutput("snooped_tdata", snoopedTdata, mSnoop);
    checkOutput("snooped_valid", snoopedValid, mSnoopValid);
    checkOutput("beat_count", beatCount, mBeat);
    checkOutput("pkt_count", pktCount, mPkt);
    checkOutput("rd_tvalid", rdTvalid, mQ.size() > 0);
    checkOutput("fill_level", fillLevel, mQ.size());
    if (mQ.size() > 0) begin
      checkOutput("rd_tdata", rdTdata, mQ[0][31:0]);
      checkOutput("rd_tlast", rdTlast, mQ[0][32]);
    end
    checkOutput("overflow", overflow, mOverflow);
    checkOutput("busy", busy, mRunning);
    checkOutput("done", done, mFinished);
  endtask

  task automatic tick();
    @(posedge clock);
    modelStep();
    #1;
    compareModel();
  endtask

  // Drives one cycle of stream input, then drops the single-cycle controls.
  task automatic applyStimulus(input logic v, input logic r, input logic l, input logic [31:0] field);
    monTvalid = v;
    monTready = r;
    monTlast  = l;
    monTdata  = {field, 32'($urandom())};
    tick();
    arm = 0; stop = 0; clear = 0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_snoop"}, snoopedTdata, 0);
    checkOutput({tag, "_svalid"}, snoopedValid, 0);
    checkOutput({tag, "_beat"}, beatCount, 0);
    checkOutput({tag, "_pkt"}, pktCount, 0);
    checkOutput({tag, "_rdata"}, rdTdata, 0);
    checkOutput({tag, "_rlast"}, rdTlast, 0);
    checkOutput({tag, "_rvalid"}, rdTvalid, 0);
    checkOutput({tag, "_fill"}, fillLevel, 0);
    checkOutput({tag, "_ovf"}, overflow, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
  endtask

  typedef struct {
    logic        v;
    logic        r;
    logic [31:0] d;
    logic [31:0] expSnoop;
    logic        expValid;
    logic [31:0] expBeat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    resetN = 0;
    monTvalid = 0; monTready = 0; monTlast = 0; monTdata = 0;
    arm = 0; stop = 0; clear = 0; mode = 0; decim = 0; rdTready = 0;
    modelReset();
    #12;
    resetN = 1;
    #1;
    checkAllZero("reset");

    // Back-to-back snoop with tready low for one cycle mid-burst.
    vecs[0] = '{1'b1, 1'b1, 32'd1, 32'd1, 1'b1, 32'd1};
    vecs[1] = '{1'b1, 1'b1, 32'd2, 32'd2, 1'b1, 32'd2};
    vecs[2] = '{1'b1, 1'b0, 32'd3, 32'd2, 1'b0, 32'd2};
    vecs[3] = '{1'b1, 1'b1, 32'd3, 32'd3, 1'b1, 32'd3};
    vecs[4] = '{1'b1, 1'b1, 32'd4, 32'd4, 1'b1, 32'd4};
    vecs[5] = '{1'b1, 1'b1, 32'd5, 32'd5, 1'b1, 32'd5};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].v, vecs[i].r, 1'b0, vecs[i].d);
      checkOutput("tbl_snoop", snoopedTdata, vecs[i].expSnoop);
      checkOutput("tbl_valid", snoopedValid, vecs[i].expValid);
      checkOutput("tbl_beat", beatCount, vecs[i].expBeat);
    end
    applyStimulus(0, 0, 0, 0);
    checkOutput("idle_no_pulse", snoopedValid, 0);

    // Continuous capture with decimation 2: keep 0, 3, 6.
    clear = 1; applyStimulus(0, 0, 0, 0);
    mode = 0; decim = 2; arm = 1; applyStimulus(0, 0, 0, 0);
    for (int i = 0; i < 9; i++) applyStimulus(1, 1, 0, i);
    checkOutput("decim_fill", fillLevel, 3);
    checkOutput("decim_busy", busy, 1);
    for (int k = 0; k < 3; k++) begin
      checkOutput("decim_drain", rdTdata, k * 3);
      rdTready = 1; applyStimulus(0, 0, 0, 0); rdTready = 0;
    end
    checkOutput("decim_empty", rdTvalid, 0);
    stop = 1; applyStimulus(0, 0, 0, 0);
    checkOutput("stop_idle", busy, 0);

    // Packet mode armed in the middle of packet A; only packet B is captured.
    clear = 1; decim = 0; applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 1, 0, 100);
    applyStimulus(1, 1, 0, 101);
    mode = 1; arm = 1; applyStimulus(0, 0, 0, 0);
    checkOutput("pkt_waitsop_busy", busy, 1);
    applyStimulus(1, 1, 0, 102);
    applyStimulus(1, 1, 1, 103);
    checkOutput("pkt_skip_a", fillLevel, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, i == 3, 10 + i);
    applyStimulus(0, 0, 0, 0);
    checkOutput("pkt_fill", fillLevel, 4);
    checkOutput("pkt_done", done, 1);
    checkOutput("pkt_count", pktCount, 2);
    for (int k = 0; k < 4; k++) begin
      checkOutput("pkt_data", rdTdata, 10 + k);
      checkOutput("pkt_last", rdTlast, k == 3);
      rdTready = 1; applyStimulus(0, 0, 0, 0); rdTready = 0;
    end

    // Overflow in continuous mode, then clear.
    clear = 1; applyStimulus(0, 0, 0, 0);
    mode = 0; decim = 0; arm = 1; applyStimulus(0, 0, 0, 0);
    for (int i = 0; i < 20; i++) applyStimulus(1, 1, 0, i);
    checkOutput("ovf_fill", fillLevel, 16);
    checkOutput("ovf_flag", overflow, 1);
    checkOutput("ovf_busy", busy, 1);
    for (int k = 0; k < 16; k++) begin
      checkOutput("ovf_data", rdTdata, k);
      rdTready = 1; applyStimulus(0, 0, 0, 0); rdTready = 0;
    end
    clear = 1; applyStimulus(0, 0, 0, 0);
    checkOutput("clr_fill", fillLevel, 0);
    checkOutput("clr_ovf", overflow, 0);
    checkOutput("clr_beat", beatCount, 0);
    checkOutput("clr_pkt", pktCount, 0);
    checkOutput("clr_busy", busy, 0);

    // Full FIFO with simultaneous write and pop.
    arm = 1; applyStimulus(0, 0, 0, 0);
    for (int i = 0; i < 16; i++) applyStimulus(1, 1, 0, 200 + i);
    checkOutput("full_fill", fillLevel, 16);
    rdTready = 1; applyStimulus(1, 1, 0, 300); rdTready = 0;
    checkOutput("full_pop_fill", fillLevel, 16);
    checkOutput("full_pop_ovf", overflow, 0);
    checkOutput("full_pop_head", rdTdata, 201);
    stop = 1; applyStimulus(0, 0, 0, 0);

    // Asynchronous reset during capture.
    arm = 1; applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 1, 0, 7);
    applyStimulus(1, 1, 0, 8);
    monTvalid = 0; monTready = 0;
    @(posedge clock);
    #3;
    resetN = 0;
    #1;
    checkAllZero("async");
    modelReset();
    #20;
    @(negedge clock);
    resetN = 1;
    mode = 0; decim = 0; arm = 1; applyStimulus(0, 0, 0, 0);
    checkOutput("rearm_busy", busy, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 50 + i);
    checkOutput("rearm_fill", fillLevel, 3);
    checkOutput("rearm_head", rdTdata, 50);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rdTready = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
      clear = ($urandom_range(0, 199) == 0);
      stop  = ($urandom_range(0, 79) == 0);
      arm   = ($urandom_range(0, 14) == 0);
      mode  = 1'($urandom_range(0, 1));
      if (arm && !mRunning) decim = 8'($urandom_range(0, 3));
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 4) == 0, $urandom());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
